ahb_slave_xfer_ctrl: RTL and testbench

Data-phase controller directly downstream of the AHB address-phase decoder (AMBAsensor). It consumes the decoder outputs (addrMatch, mWrite, mRead, invalid) and drives the slave response (HREADYOUT, HRESP, HRDATA). Accepted write beats are buffered in a small FIFO for the 128-bit processing core. Read beats return the core's result word, with wait states inserted until the result is available.

---
 rtl/ahb_slave_xfer_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ahb_slave_xfer_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_xfer_ctrl.sv
// AHB slave data-phase controller: write beats into a small FIFO, read beats return the core
// result word with wait states. Optional read timeout enabled by the RD_TIMEOUT_EN macro.
module ahb_slave_xfer_ctrl #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_TIMEOUT = 16
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic                        HSELx,
    input  logic                        HREADY,
    input  logic                        addrMatch,
    input  logic                        mWrite,
    input  logic                        mRead,
    input  logic                        invalid,
    input  logic [DATA_W-1:0]           HWDATA,
    output logic [DATA_W-1:0]           HRDATA,
    output logic                        HREADYOUT,
    output logic                        HRESP,
    input  logic [DATA_W-1:0]           res_data,
    input  logic                        res_valid,
    output logic                        res_ack,
    output logic [DATA_W-1:0]           fifo_rdata,
    output logic                        fifo_empty,
    input  logic                        fifo_pop,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RD_TIMEOUT == 0)
    begin : g_param_check
        $error("ahb_slave_xfer_ctrl: FIFO_DEPTH must be a power of 2 >= 2, RD_TIMEOUT > 0");
    end

    typedef enum logic [2:0] {
        StIdle,
        StWdata,
        StRdata,
        StErr1,
        StErr2
    } state_e;

    state_e state_q, state_d;
    state_e idle_next;

    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic              ack_q, ack_d;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              accept;
    logic              rd_timeout;

    assign accept     = HSELx & HREADY & addrMatch;
    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_count = count_q;
    assign fifo_rdata = mem_q[rd_ptr_q];
    assign HRDATA     = hrdata_q;
    assign res_ack    = ack_q;
    assign pop        = fifo_pop & ~fifo_empty;

    // Address-phase decode; invalid outranks any transfer direction.
    always_comb begin
        idle_next = StIdle;
        if (accept) begin
            if (invalid) begin
                idle_next = StErr1;
            end else if (mWrite) begin
                idle_next = StWdata;
            end else if (mRead) begin
                idle_next = StRdata;
            end
        end
    end

`ifdef RD_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(RD_TIMEOUT + 1);

    logic [TmoW-1:0] wait_cnt_q, wait_cnt_d;

    // Any cycle that is not an RDATA wait clears the count, so it restarts at each RDATA entry.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == StRdata && !res_valid) begin
            wait_cnt_d = wait_cnt_q + TmoW'(1);
        end
    end

    assign rd_timeout = (state_q == StRdata) && !res_valid && (wait_cnt_d == TmoW'(RD_TIMEOUT));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign rd_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        push      = 1'b0;
        ack_d     = 1'b0;
        hrdata_d  = hrdata_q;
        case (state_q)
            StIdle: begin
                state_d = idle_next;
            end
            StWdata: begin
                HREADYOUT = ~fifo_full;
                if (!fifo_full) begin
                    push    = 1'b1;
                    state_d = idle_next;
                end
            end
            StRdata: begin
                // Completion is seen by the bus in the following IDLE cycle, with HRDATA registered.
                HREADYOUT = 1'b0;
                if (res_valid) begin
                    hrdata_d = res_data;
                    ack_d    = 1'b1;
                    state_d  = idle_next;
                end else if (rd_timeout) begin
                    state_d = StErr1;
                end
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = StErr2;
            end
            StErr2: begin
                HRESP   = 1'b1;
                state_d = idle_next;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= StIdle;
            hrdata_q <= '0;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            hrdata_q <= hrdata_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push && !HRESET) begin
            mem_q[wr_ptr_q] <= HWDATA;
        end
    end

endmodule

// File: tb/tb_ahb_slave_xfer_ctrl.sv
// Directed, table-driven bench for ahb_slave_xfer_ctrl (single slave: HREADY looped back).
module tb_ahb_slave_xfer_ctrl;

    localparam int unsigned DW  = 128;
    localparam int unsigned TMO = 16;
    localparam int unsigned NV  = 38;

    // {HSELx, addrMatch, mWrite, mRead, invalid}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_WR   = 5'b11100;
    localparam logic [4:0] C_RD   = 5'b11010;
    localparam logic [4:0] C_INV  = 5'b11101;
    localparam logic [4:0] C_INVR = 5'b11011;
    localparam logic [4:0] C_NOP  = 5'b11000;
    localparam logic [4:0] C_MISS = 5'b10100;

    localparam logic [DW-1:0] DA = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [DW-1:0] DB = 128'h11111111_22222222_33333333_44444444;
    localparam logic [DW-1:0] DC = 128'h55555555_66666666_77777777_88888888;
    localparam logic [DW-1:0] DD = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
    localparam logic [DW-1:0] DE = 128'hEEEEEEEE_0000000E_FFFFFFFF_1234ABCD;
    localparam logic [DW-1:0] DF = 128'h0F0F0F0F_F0F0F0F0_0F0F0F0F_F0F0F0F0;
    localparam logic [DW-1:0] DG = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
    localparam logic [DW-1:0] DH = 128'h00000000_00000000_00000000_0000BEEF;
    localparam logic [DW-1:0] DI = 128'h13579BDF_2468ACE0_13579BDF_2468ACE0;
    localparam logic [DW-1:0] DX = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

    typedef struct {
        logic [4:0]    ctl;
        logic [DW-1:0] hw;
        logic          pop;
        logic          rv;
        logic [DW-1:0] rd;
        logic          e_rdy;
        logic          e_resp;
        logic          e_ack;
        logic [2:0]    e_cnt;
        logic          chk_fd;
        logic [DW-1:0] e_fd;
        logic [DW-1:0] e_hr;
    } vec_t;

    logic          HCLK, HRESET, HSELx, HREADY, addrMatch, mWrite, mRead, invalid;
    logic [DW-1:0] HWDATA, HRDATA, res_data, fifo_rdata;
    logic          HREADYOUT, HRESP, res_valid, res_ack, fifo_empty, fifo_pop;
    logic [2:0]    fifo_count;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NV];

    assign HREADY = HREADYOUT;

    ahb_slave_xfer_ctrl #(
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .RD_TIMEOUT (TMO)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSELx      (HSELx),
        .HREADY     (HREADY),
        .addrMatch  (addrMatch),
        .mWrite     (mWrite),
        .mRead      (mRead),
        .invalid    (invalid),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ack    (res_ack),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_count (fifo_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [DW-1:0] hw, input logic pop,
                         input logic rv, input logic [DW-1:0] rd);
        {HSELx, addrMatch, mWrite, mRead, invalid} = ctl;
        HWDATA    = hw;
        fifo_pop  = pop;
        res_valid = rv;
        res_data  = rd;
    endtask

    function automatic vec_t mkv(input logic [4:0] ctl, input logic [DW-1:0] hw,
                                 input logic pop, input logic rv, input logic [DW-1:0] rd,
                                 input logic rdy, input logic resp, input logic ack,
                                 input logic [2:0] cnt, input logic chk_fd,
                                 input logic [DW-1:0] fd, input logic [DW-1:0] hr);
        vec_t v;
        v.ctl = ctl; v.hw = hw; v.pop = pop; v.rv = rv; v.rd = rd;
        v.e_rdy = rdy; v.e_resp = resp; v.e_ack = ack; v.e_cnt = cnt;
        v.chk_fd = chk_fd; v.e_fd = fd; v.e_hr = hr;
        return v;
    endfunction

    initial begin
        // Expected values describe the cycle after the edge that samples the inputs.
        vecs[0]  = mkv(C_WR,   '0, 0, 0, '0, 1, 0, 0, 0, 0, '0, '0);
        vecs[1]  = mkv(C_NONE, DA, 0, 0, '0, 1, 0, 0, 1, 1, DA, '0);
        vecs[2]  = mkv(C_WR,   '0, 0, 0, '0, 1, 0, 0, 1, 1, DA, '0);
        vecs[3]  = mkv(C_WR,   DB, 0, 0, '0, 1, 0, 0, 2, 1, DA, '0);
        vecs[4]  = mkv(C_WR,   DC, 0, 0, '0, 1, 0, 0, 3, 1, DA, '0);
        vecs[5]  = mkv(C_WR,   DD, 0, 0, '0, 0, 0, 0, 4, 1, DA, '0);
        vecs[6]  = mkv(C_NONE, DE, 0, 0, '0, 0, 0, 0, 4, 1, DA, '0);
        vecs[7]  = mkv(C_NONE, DE, 1, 0, '0, 1, 0, 0, 3, 1, DB, '0);
        vecs[8]  = mkv(C_NONE, DE, 0, 0, '0, 1, 0, 0, 4, 1, DB, '0);
        vecs[9]  = mkv(C_NONE, '0, 1, 0, '0, 1, 0, 0, 3, 1, DC, '0);
        vecs[10] = mkv(C_NONE, '0, 1, 0, '0, 1, 0, 0, 2, 1, DD, '0);
        vecs[11] = mkv(C_NONE, '0, 1, 0, '0, 1, 0, 0, 1, 1, DE, '0);
        vecs[12] = mkv(C_NONE, '0, 1, 0, '0, 1, 0, 0, 0, 0, '0, '0);
        vecs[13] = mkv(C_NONE, '0, 1, 0, '0, 1, 0, 0, 0, 0, '0, '0);
        vecs[14] = mkv(C_WR,   '0, 0, 0, '0, 1, 0, 0, 0, 0, '0, '0);
        vecs[15] = mkv(C_NONE, DF, 0, 0, '0, 1, 0, 0, 1, 1, DF, '0);
        vecs[16] = mkv(C_WR,   '0, 0, 0, '0, 1, 0, 0, 1, 1, DF, '0);
        vecs[17] = mkv(C_NONE, DG, 1, 0, '0, 1, 0, 0, 1, 1, DG, '0);
        vecs[18] = mkv(C_NONE, '0, 1, 0, '0, 1, 0, 0, 0, 0, '0, '0);
        vecs[19] = mkv(C_RD,   '0, 0, 0, '0, 0, 0, 0, 0, 0, '0, '0);
        vecs[20] = mkv(C_NONE, '0, 0, 0, '0, 0, 0, 0, 0, 0, '0, '0);
        vecs[21] = mkv(C_NONE, '0, 0, 0, '0, 0, 0, 0, 0, 0, '0, '0);
        vecs[22] = mkv(C_NONE, '0, 0, 1, 128'h1234, 1, 0, 1, 0, 0, '0, 128'h1234);
        vecs[23] = mkv(C_NONE, '0, 0, 1, 128'h9999, 1, 0, 0, 0, 0, '0, 128'h1234);
        vecs[24] = mkv(C_INV,  '0, 0, 0, '0, 0, 1, 0, 0, 0, '0, 128'h1234);
        vecs[25] = mkv(C_NONE, DX, 0, 0, '0, 1, 1, 0, 0, 0, '0, 128'h1234);
        vecs[26] = mkv(C_NONE, DX, 0, 0, '0, 1, 0, 0, 0, 0, '0, 128'h1234);
        vecs[27] = mkv(C_INVR, '0, 0, 1, 128'h77, 0, 1, 0, 0, 0, '0, 128'h1234);
        vecs[28] = mkv(C_WR,   DX, 0, 1, 128'h77, 1, 1, 0, 0, 0, '0, 128'h1234);
        vecs[29] = mkv(C_WR,   DX, 0, 0, '0, 1, 0, 0, 0, 0, '0, 128'h1234);
        vecs[30] = mkv(C_NONE, DH, 0, 0, '0, 1, 0, 0, 1, 1, DH, 128'h1234);
        vecs[31] = mkv(C_NOP,  DX, 0, 0, '0, 1, 0, 0, 1, 1, DH, 128'h1234);
        vecs[32] = mkv(C_MISS, DX, 0, 0, '0, 1, 0, 0, 1, 1, DH, 128'h1234);
        vecs[33] = mkv(C_NONE, DX, 0, 0, '0, 1, 0, 0, 1, 1, DH, 128'h1234);
        vecs[34] = mkv(C_WR,   '0, 1, 0, '0, 1, 0, 0, 0, 0, '0, 128'h1234);
        vecs[35] = mkv(C_RD,   DI, 0, 0, '0, 0, 0, 0, 1, 1, DI, 128'h1234);
        vecs[36] = mkv(C_NONE, '0, 0, 1, 128'h5678, 1, 0, 1, 1, 1, DI, 128'h5678);
        vecs[37] = mkv(C_NONE, '0, 1, 0, '0, 1, 0, 0, 0, 0, '0, 128'h5678);

        HRESET = 1'b1;
        drive(C_NONE, '0, 0, 0, '0);
        repeat (2) step();
        chk("reset HREADYOUT", HREADYOUT, 1);
        chk("reset HRESP", HRESP, 0);
        chk("reset fifo_empty", fifo_empty, 1);
        chk("reset fifo_count", fifo_count, 0);
        chk("reset res_ack", res_ack, 0);
        chk("reset HRDATA", HRDATA, '0);
        HRESET = 1'b0;

        for (int i = 0; i < int'(NV); i++) begin
            drive(vecs[i].ctl, vecs[i].hw, vecs[i].pop, vecs[i].rv, vecs[i].rd);
            step();
            chk($sformatf("v%0d HREADYOUT", i), HREADYOUT, vecs[i].e_rdy);
            chk($sformatf("v%0d HRESP", i), HRESP, vecs[i].e_resp);
            chk($sformatf("v%0d res_ack", i), res_ack, vecs[i].e_ack);
            chk($sformatf("v%0d fifo_count", i), fifo_count, vecs[i].e_cnt);
            chk($sformatf("v%0d fifo_empty", i), fifo_empty, vecs[i].e_cnt == 3'd0);
            chk($sformatf("v%0d HRDATA", i), HRDATA, vecs[i].e_hr);
            if (vecs[i].chk_fd) begin
                chk($sformatf("v%0d fifo_rdata", i), fifo_rdata, vecs[i].e_fd);
            end
        end

        // Reset in the middle of a read wait, with a buffered write pending.
        drive(C_WR, '0, 0, 0, '0);
        step();
        drive(C_NONE, DA, 0, 0, '0);
        step();
        chk("midrst pre count", fifo_count, 1);
        drive(C_RD, '0, 0, 0, '0);
        step();
        chk("midrst in read", HREADYOUT, 0);
        drive(C_NONE, '0, 0, 1, 128'hABCD);
        HRESET = 1'b1;
        step();
        chk("midrst HREADYOUT", HREADYOUT, 1);
        chk("midrst HRESP", HRESP, 0);
        chk("midrst res_ack", res_ack, 0);
        chk("midrst HRDATA", HRDATA, '0);
        chk("midrst fifo_count", fifo_count, 0);
        chk("midrst fifo_empty", fifo_empty, 1);
        HRESET = 1'b0;
        drive(C_NONE, '0, 0, 0, '0);
        step();
        chk("postrst res_ack", res_ack, 0);
        chk("postrst HREADYOUT", HREADYOUT, 1);

`ifdef RD_TIMEOUT_EN
        drive(C_RD, '0, 0, 0, '0);
        step();
        drive(C_NONE, '0, 0, 0, '0);
        for (int k = 0; k < int'(TMO); k++) begin
            chk($sformatf("tmo wait%0d HREADYOUT", k), HREADYOUT, 0);
            chk($sformatf("tmo wait%0d HRESP", k), HRESP, 0);
            chk($sformatf("tmo wait%0d res_ack", k), res_ack, 0);
            step();
        end
        chk("tmo err1 HREADYOUT", HREADYOUT, 0);
        chk("tmo err1 HRESP", HRESP, 1);
        chk("tmo err1 res_ack", res_ack, 0);
        step();
        chk("tmo err2 HREADYOUT", HREADYOUT, 1);
        chk("tmo err2 HRESP", HRESP, 1);
        chk("tmo err2 res_ack", res_ack, 0);
        step();
        chk("tmo idle HREADYOUT", HREADYOUT, 1);
        chk("tmo idle HRESP", HRESP, 0);
        chk("tmo idle HRDATA", HRDATA, '0);
`else
        drive(C_RD, '0, 0, 0, '0);
        step();
        drive(C_NONE, '0, 0, 0, '0);
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("nowait%0d HREADYOUT", k), HREADYOUT, 0);
            chk($sformatf("nowait%0d HRESP", k), HRESP, 0);
            step();
        end
        drive(C_NONE, '0, 0, 1, 128'h77);
        step();
        chk("longread HREADYOUT", HREADYOUT, 1);
        chk("longread res_ack", res_ack, 1);
        chk("longread HRDATA", HRDATA, 128'h77);
        drive(C_NONE, '0, 0, 0, '0);
        step();
        chk("longread ack drop", res_ack, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
